// File: rtl/instruction_fetch_sequencer_pkg.sv
// Shared encodings for the fetch sequencer and the address register file.
package instruction_fetch_sequencer_pkg;

  // Address register file function selects
  localparam logic [2:0] FUNSEL_NOP   = 3'b000;
  localparam logic [2:0] FUNSEL_INC   = 3'b001;
  localparam logic [2:0] FUNSEL_LOAD  = 3'b010;
  localparam logic [2:0] FUNSEL_CLEAR = 3'b011;

  // Active-low register enables: bit2 PC, bit1 AR, bit0 SP
  localparam logic [2:0] REGSEL_PC_ONLY = 3'b011;
  localparam logic [2:0] REGSEL_NONE    = 3'b111;

  // OutD source: PC drives the memory address
  localparam logic [1:0] OUTDSEL_PC = 2'b00;

  typedef enum logic [1:0] {
    CMD_FETCH    = 2'b00,
    CMD_JUMP     = 2'b01,
    CMD_CLEAR_PC = 2'b10,
    CMD_NOP      = 2'b11
  } cmd_e;

  typedef enum logic [3:0] {
    ST_RST,
    ST_INIT,
    ST_IDLE,
    ST_RD_LO,
    ST_CAP_LO,
    ST_RD_HI,
    ST_CAP_HI,
    ST_DONE,
    ST_JMP,
    ST_CLR
  } state_e;

endpackage

// File: rtl/instruction_fetch_sequencer.sv
// Drives PC updates in the address register file and assembles a
// little-endian 16-bit instruction from two byte reads at PC and PC+1.
module instruction_fetch_sequencer
  import instruction_fetch_sequencer_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        CmdValid,
  output logic        CmdReady,
  input  logic [1:0]  Cmd,
  input  logic [15:0] CmdAddr,
  output logic [15:0] ArfI,
  output logic [2:0]  ArfFunSel,
  output logic [2:0]  ArfRegSel,
  output logic [1:0]  ArfOutDSel,
  output logic        MemRead,
  input  logic [7:0]  MemData,
  output logic [15:0] Ir,
  output logic        IrValid,
  input  logic        IrAck
);

  state_e      state;
  logic        cmd_ready_q;
  logic        ir_valid_q;
  logic        mem_read_q;
  logic [2:0]  regsel_q;
  logic [2:0]  funsel_q;
  logic [15:0] arf_i_q;
  logic [15:0] ir_q;
  logic        accept;

  assign accept = CmdValid & cmd_ready_q;

  // State machine; every output register is loaded with the value for the state being entered
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= ST_RST;
      cmd_ready_q <= 1'b0;
      ir_valid_q  <= 1'b0;
      mem_read_q  <= 1'b0;
      regsel_q    <= REGSEL_NONE;
      funsel_q    <= FUNSEL_NOP;
      arf_i_q     <= '0;
      ir_q        <= '0;
    end else begin
      regsel_q   <= REGSEL_NONE;
      funsel_q   <= FUNSEL_NOP;
      mem_read_q <= 1'b0;
      arf_i_q    <= '0;
      unique case (state)
        ST_RST: begin
          state    <= ST_INIT;
          regsel_q <= REGSEL_PC_ONLY;
          funsel_q <= FUNSEL_CLEAR;
        end
        ST_INIT: begin
          state       <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        ST_IDLE: begin
          if (accept) begin
            unique case (cmd_e'(Cmd))
              CMD_FETCH: begin
                state       <= ST_RD_LO;
                cmd_ready_q <= 1'b0;
                mem_read_q  <= 1'b1;
              end
              CMD_JUMP: begin
                state       <= ST_JMP;
                cmd_ready_q <= 1'b0;
                regsel_q    <= REGSEL_PC_ONLY;
                funsel_q    <= FUNSEL_LOAD;
                arf_i_q     <= CmdAddr;
              end
              CMD_CLEAR_PC: begin
                state       <= ST_CLR;
                cmd_ready_q <= 1'b0;
                regsel_q    <= REGSEL_PC_ONLY;
                funsel_q    <= FUNSEL_CLEAR;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        ST_RD_LO: begin
          state    <= ST_CAP_LO;
          regsel_q <= REGSEL_PC_ONLY;
          funsel_q <= FUNSEL_INC;
        end
        ST_CAP_LO: begin
          ir_q[7:0]  <= MemData;
          state      <= ST_RD_HI;
          mem_read_q <= 1'b1;
        end
        ST_RD_HI: begin
          state    <= ST_CAP_HI;
          regsel_q <= REGSEL_PC_ONLY;
          funsel_q <= FUNSEL_INC;
        end
        ST_CAP_HI: begin
          ir_q[15:8] <= MemData;
          state      <= ST_DONE;
          ir_valid_q <= 1'b1;
        end
        ST_DONE: begin
          if (IrAck) begin
            state       <= ST_IDLE;
            ir_valid_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        ST_JMP, ST_CLR: begin
          state       <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
        default: state <= ST_RST;
      endcase
    end
  end

  // Outputs are registered one state ahead, so a reset landing mid-fetch would
  // still present that state's PC increment / read at the reset edge; masking the
  // write enables and read strobe with Reset aborts them at that same edge.
  assign ArfRegSel  = Reset ? regsel_q : REGSEL_NONE;
  assign ArfFunSel  = Reset ? funsel_q : FUNSEL_NOP;
  assign MemRead    = Reset & mem_read_q;
  assign ArfI       = arf_i_q;
  assign ArfOutDSel = OUTDSEL_PC;
  assign CmdReady   = cmd_ready_q;
  assign IrValid    = ir_valid_q;
  assign Ir         = ir_q;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// Bench for instruction_fetch_sequencer with behavioural register file and memory.
module tb_instruction_fetch_sequencer;
  import instruction_fetch_sequencer_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        CmdValid = 1'b0;
  logic        CmdReady;
  logic [1:0]  Cmd = 2'b11;
  logic [15:0] CmdAddr = '0;
  logic [15:0] ArfI;
  logic [2:0]  ArfFunSel;
  logic [2:0]  ArfRegSel;
  logic [1:0]  ArfOutDSel;
  logic        MemRead;
  logic [7:0]  MemData;
  logic [15:0] Ir;
  logic        IrValid;
  logic        IrAck = 1'b0;

  always #5 Clock = ~Clock;

  instruction_fetch_sequencer dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .CmdValid   (CmdValid),
    .CmdReady   (CmdReady),
    .Cmd        (Cmd),
    .CmdAddr    (CmdAddr),
    .ArfI       (ArfI),
    .ArfFunSel  (ArfFunSel),
    .ArfRegSel  (ArfRegSel),
    .ArfOutDSel (ArfOutDSel),
    .MemRead    (MemRead),
    .MemData    (MemData),
    .Ir         (Ir),
    .IrValid    (IrValid),
    .IrAck      (IrAck)
  );

  // Address register file model
  logic [15:0] pc = 16'h5555;
  logic [15:0] ar = 16'h1111;
  logic [15:0] sp = 16'h2222;

  function automatic logic [15:0] arf_next(input logic [15:0] cur, input logic [2:0] fs,
                                           input logic [15:0] din);
    case (fs)
      3'b010:  return din;
      3'b011:  return 16'h0000;
      3'b001:  return cur + 16'h0001;
      default: return cur;
    endcase
  endfunction

  always @(posedge Clock) begin
    if (!ArfRegSel[2]) pc <= arf_next(pc, ArfFunSel, ArfI);
    if (!ArfRegSel[1]) ar <= arf_next(ar, ArfFunSel, ArfI);
    if (!ArfRegSel[0]) sp <= arf_next(sp, ArfFunSel, ArfI);
  end

  // Byte memory, synchronous read addressed by PC (OutD)
  logic [7:0] mem [0:65535];
  logic [7:0] mem_q;
  always @(posedge Clock) if (MemRead) mem_q <= mem[pc];
  assign MemData = mem_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Presents a command at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [1:0] c, input logic [15:0] a);
    int n = 0;
    while (!CmdReady && n < 20) begin
      tick();
      n++;
    end
    chk("cmd_ready_before_issue", CmdReady, 1);
    CmdValid = 1'b1;
    Cmd      = c;
    CmdAddr  = a;
    tick();
    CmdValid = 1'b0;
    Cmd      = CMD_NOP;
  endtask

  task automatic run_fetch(input logic [15:0] exp_ir, input logic [15:0] exp_pc, input int hold);
    logic [7:0] rd_mask = '0;
    int first = 0;
    issue(CMD_FETCH, 16'h0000);
    for (int k = 1; k <= 8; k++) begin
      if (MemRead) rd_mask[k-1] = 1'b1;
      chk("fetch_busy_not_ready", CmdReady, 0);
      if (IrValid) begin
        first = k;
        break;
      end
      tick();
    end
    chk("fetch_memread_cycles", rd_mask, 8'b0000_0101);
    chk("fetch_irvalid_latency", first, 5);
    chk("fetch_ir", Ir, exp_ir);
    chk("fetch_pc", pc, exp_pc);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_irvalid", IrValid, 1);
      chk("hold_ir", Ir, exp_ir);
    end
    IrAck = 1'b1;
    tick();
    IrAck = 1'b0;
    chk("ack_irvalid_low", IrValid, 0);
    chk("ack_ready_high", CmdReady, 1);
  endtask

  task automatic run_ctl(input logic [1:0] c, input logic [15:0] a, input logic [15:0] exp_pc);
    issue(c, a);
    if (c == CMD_NOP) begin
      chk("nop_ready", CmdReady, 1);
      chk("nop_regsel", ArfRegSel, 3'b111);
    end else begin
      chk("ctl_regsel", ArfRegSel, 3'b011);
      chk("ctl_funsel", ArfFunSel, (c == CMD_JUMP) ? 3'b010 : 3'b011);
      if (c == CMD_JUMP) chk("jmp_arfi", ArfI, a);
      chk("ctl_busy", CmdReady, 0);
    end
    tick();
    chk("ctl_regsel_after", ArfRegSel, 3'b111);
    chk("ctl_ready_after", CmdReady, 1);
    chk("ctl_pc", pc, exp_pc);
    chk("ctl_ar_kept", ar, 16'h1111);
    chk("ctl_sp_kept", sp, 16'h2222);
  endtask

  typedef struct {
    logic [1:0]  cmd;
    logic [15:0] addr;
    int          hold;
    logic [15:0] exp_ir;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [11:0] rd_mask;
    logic [11:0] iv_mask;
    logic [11:0] rdy_mask;
    logic [3:0]  idle_rd;

    vecs[0] = '{CMD_FETCH,    16'h0000, 4, 16'h1234, 16'h0002};
    vecs[1] = '{CMD_FETCH,    16'h0000, 0, 16'h5678, 16'h0004};
    vecs[2] = '{CMD_JUMP,     16'h0040, 0, 16'h0000, 16'h0040};
    vecs[3] = '{CMD_NOP,      16'h0000, 0, 16'h0000, 16'h0040};
    vecs[4] = '{CMD_CLEAR_PC, 16'h0000, 0, 16'h0000, 16'h0000};
    vecs[5] = '{CMD_JUMP,     16'h0040, 0, 16'h0000, 16'h0040};
    vecs[6] = '{CMD_FETCH,    16'h0000, 1, 16'hBEEF, 16'h0042};
    vecs[7] = '{CMD_JUMP,     16'hFFFF, 0, 16'h0000, 16'hFFFF};

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h34;
    mem[16'h0001] = 8'h12;
    mem[16'h0002] = 8'h78;
    mem[16'h0003] = 8'h56;
    mem[16'h0004] = 8'h9A;
    mem[16'h0040] = 8'hEF;
    mem[16'h0041] = 8'hBE;
    mem[16'hFFFF] = 8'hCD;

    // Reset held low for three cycles
    @(negedge Clock);
    repeat (3) tick();
    chk("rst_cmd_ready", CmdReady, 0);
    chk("rst_irvalid", IrValid, 0);
    chk("rst_ir", Ir, 16'h0000);
    chk("rst_memread", MemRead, 0);
    chk("rst_regsel", ArfRegSel, 3'b111);
    chk("rst_funsel", ArfFunSel, 3'b000);
    chk("rst_arfi", ArfI, 16'h0000);
    chk("outdsel", ArfOutDSel, 2'b00);
    Reset = 1'b1;
    tick();
    chk("init_regsel", ArfRegSel, 3'b011);
    chk("init_funsel", ArfFunSel, 3'b011);
    chk("init_not_ready", CmdReady, 0);
    tick();
    chk("idle_ready", CmdReady, 1);
    chk("idle_regsel", ArfRegSel, 3'b111);
    chk("init_pc_cleared", pc, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].cmd == CMD_FETCH) run_fetch(vecs[i].exp_ir, vecs[i].exp_pc, vecs[i].hold);
      else run_ctl(vecs[i].cmd, vecs[i].addr, vecs[i].exp_pc);
    end

    // PC wrap: low byte at FFFF, high byte at 0000
    mem[16'h0000] = 8'hAB;
    run_fetch(16'hABCD, 16'h0001, 0);

    // Back-to-back fetches with CmdValid held through the busy states
    CmdValid = 1'b1;
    Cmd      = CMD_FETCH;
    rd_mask  = '0;
    iv_mask  = '0;
    rdy_mask = '0;
    tick();
    for (int k = 1; k <= 12; k++) begin
      rd_mask[k-1]  = MemRead;
      iv_mask[k-1]  = IrValid;
      rdy_mask[k-1] = CmdReady;
      if (k == 5) begin
        chk("b2b_ir1", Ir, 16'h7812);
        chk("b2b_pc1", pc, 16'h0003);
        IrAck = 1'b1;
      end
      if (k == 6) IrAck = 1'b0;
      if (k == 7) begin
        CmdValid = 1'b0;
        Cmd      = CMD_NOP;
      end
      if (k == 11) begin
        chk("b2b_ir2", Ir, 16'h9A56);
        chk("b2b_pc2", pc, 16'h0005);
        IrAck = 1'b1;
      end
      if (k == 12) IrAck = 1'b0;
      if (k < 12) tick();
    end
    chk("b2b_memread", rd_mask, 12'h145);
    chk("b2b_irvalid", iv_mask, 12'h410);
    chk("b2b_ready", rdy_mask, 12'h820);

    // Reset pulsed while in CAP_LO
    issue(CMD_FETCH, 16'h0000);
    tick();
    Reset = 1'b0;
    tick();
    chk("midrst_pc_kept", pc, 16'h0005);
    chk("midrst_ir", Ir, 16'h0000);
    chk("midrst_irvalid", IrValid, 0);
    chk("midrst_memread", MemRead, 0);
    chk("midrst_ready", CmdReady, 0);
    Reset = 1'b1;
    tick();
    chk("midrst_init_regsel", ArfRegSel, 3'b011);
    chk("midrst_init_funsel", ArfFunSel, 3'b011);
    tick();
    chk("midrst_pc_cleared", pc, 16'h0000);
    chk("midrst_ready_back", CmdReady, 1);
    idle_rd = '0;
    for (int k = 0; k < 4; k++) begin
      idle_rd[k] = MemRead;
      tick();
    end
    chk("midrst_no_read", idle_rd, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
